fetch_stage: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline, directly upstream of InstMEM. Owns the PC register,

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_next_pc_mux.sv | 41 ++++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the MIPS fetch stage: reset/exception vectors,
// the bubble word, fetch FSM state codes and the IF/ID register layout.
package fetch_stage_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_EXC_PC   = 32'h8000_0004;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// Next-PC selection for the fetch stage: fixed-priority redirect select, pending
// target and the sequential PC+4 adder.
module next_pc_mux
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] EXC_PC = FETCH_EXC_PC
) (
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_pc,
  output logic        redirect,
  output logic [31:0] redirect_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    redirect        = 1'b1;
    redirect_target = pc_plus4;
    if (exception)         redirect_target = word_align(EXC_PC);
    else if (jump_reg)     redirect_target = word_align(jump_reg_target);
    else if (branch_taken) redirect_target = word_align(branch_target);
    else if (jump)         redirect_target = word_align(jump_target);
    else                   redirect        = 1'b0;
  end

  // A fresh redirect beats a held one; the held one beats sequential flow.
  assign next_pc = redirect   ? redirect_target :
                   pend_valid ? pend_pc         : pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, InstMEM address, IF/ID
// register, and a one-entry holding slot for redirects that arrive while stalled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] EXC_PC   = FETCH_EXC_PC,
  parameter logic [31:0] NOP      = FETCH_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Exception,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] PCOut,
  input  logic [31:0] InstIn,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  logic [31:0] pc;
  logic [0:0]  state;
  logic [31:0] pend_pc;
  if_id_t      if_id_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pc_load;
  logic        load_bubble;

  next_pc_mux #(
    .EXC_PC (EXC_PC)
  ) u_next_pc_mux (
    .pc              (pc),
    .exception       (Exception),
    .jump_reg        (JumpReg),
    .jump_reg_target (JumpRegTarget),
    .branch_taken    (BranchTaken),
    .branch_target   (BranchTarget),
    .jump            (Jump),
    .jump_target     (JumpTarget),
    .pend_valid      (state == ST_PEND),
    .pend_pc         (pend_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc)
  );

  // Exception is the only source that moves the PC through a stall.
  assign pc_load = Exception || !Stall;

  // Any PC change other than sequential flow squashes the word fetched this cycle.
  assign load_bubble = Exception || Flush || (!Stall && (redirect || state == ST_PEND));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pc      <= RESET_PC;
      state   <= ST_RUN;
      pend_pc <= '0;
      if_id_q <= '{instruction: NOP, pc_plus4: 32'h0, valid: 1'b0};
    end else begin
      if (pc_load) pc <= next_pc;

      if (load_bubble)  if_id_q <= '{instruction: NOP, pc_plus4: 32'h0, valid: 1'b0};
      else if (!Stall)  if_id_q <= '{instruction: InstIn, pc_plus4: pc_plus4, valid: 1'b1};

      // Newest redirect during a stall overwrites whatever is already held.
      if (pc_load) begin
        state <= ST_RUN;
      end else if (redirect) begin
        state   <= ST_PEND;
        pend_pc <= redirect_target;
      end
    end
  end

  assign PCOut             = pc;
  assign IF_ID_Instruction = if_id_q.instruction;
  assign IF_ID_PCPlus4     = if_id_q.pc_plus4;
  assign IF_ID_Valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed hazard scenarios followed by
// random traffic, all compared against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] EXC_PC = 32'h8000_0004;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        Stall, Flush, Exception, JumpReg, BranchTaken, Jump;
  logic [31:0] JumpRegTarget, BranchTarget, JumpTarget;
  logic [31:0] PCOut, InstIn;
  logic [31:0] IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_Valid;

  int checks = 0;
  int errors = 0;

  // Behavioural view of the stage: architectural PC, IF/ID contents, held redirect.
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_v;
  logic [31:0] pend_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign InstIn = mem(PCOut);

  fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .Exception         (Exception),
    .JumpReg           (JumpReg),
    .JumpRegTarget     (JumpRegTarget),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .Jump              (Jump),
    .JumpTarget        (JumpTarget),
    .PCOut             (PCOut),
    .InstIn            (InstIn),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_ins = NOP; m_p4 = 32'h0; m_v = 1'b0;
    pend_q.delete();
  endtask

  task automatic m_bubble();
    m_ins = NOP; m_p4 = 32'h0; m_v = 1'b0;
  endtask

  // Applies one clock edge's worth of the fetch rules to the model.
  task automatic model_edge();
    logic        have;
    logic [31:0] tgt;
    have = 1'b1;
    tgt  = 32'h0;
    if (Exception)        tgt = EXC_PC;
    else if (JumpReg)     tgt = JumpRegTarget & ~32'h3;
    else if (BranchTaken) tgt = BranchTarget & ~32'h3;
    else if (Jump)        tgt = JumpTarget & ~32'h3;
    else                  have = 1'b0;

    if (Exception) begin
      m_pc = EXC_PC;
      m_bubble();
      pend_q.delete();
    end else if (Stall) begin
      if (have) begin
        pend_q.delete();
        pend_q.push_back(tgt);
      end
      if (Flush) m_bubble();
    end else begin
      if (have) begin
        m_pc = tgt;
        m_bubble();
      end else if (pend_q.size() != 0) begin
        m_pc = pend_q.pop_front();
        m_bubble();
      end else begin
        m_ins = mem(m_pc);
        m_p4  = m_pc + 32'd4;
        m_v   = 1'b1;
        m_pc  = m_pc + 32'd4;
      end
      if (Flush) m_bubble();
      pend_q.delete();
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("pc",    PCOut,             m_pc);
    check("inst",  IF_ID_Instruction, m_ins);
    check("pc4",   IF_ID_PCPlus4,     m_p4);
    check("valid", {31'h0, IF_ID_Valid}, {31'h0, m_v});
  endtask

  task automatic clear_inputs();
    Stall = 0; Flush = 0; Exception = 0; JumpReg = 0; BranchTaken = 0; Jump = 0;
  endtask

  initial begin
    int hits;
    clear_inputs();
    JumpRegTarget = '0; BranchTarget = '0; JumpTarget = '0;
    reset = 1'b0;
    m_reset();
    #2;
    check("rst_pc",    PCOut,             32'h0);
    check("rst_inst",  IF_ID_Instruction, NOP);
    check("rst_pc4",   IF_ID_PCPlus4,     32'h0);
    check("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    #1 reset = 1'b1;

    // Sequential fetch from the reset vector.
    for (int i = 0; i < 8; i++) begin
      step();
      check("seq_pc",  PCOut,         32'(4 * (i + 1)));
      check("seq_pc4", IF_ID_PCPlus4, 32'(4 * (i + 1)));
    end

    // Taken branch at PC=0x20.
    BranchTaken = 1; BranchTarget = 32'h40;
    step();
    check("br_pc",    PCOut, 32'h40);
    check("br_valid", {31'h0, IF_ID_Valid}, 32'h0);
    BranchTaken = 0;
    step();
    check("br_inst", IF_ID_Instruction, mem(32'h40));
    check("br_pc4",  IF_ID_PCPlus4,     32'h44);

    // Jump arriving in the first of three stall cycles.
    Stall = 1; Jump = 1; JumpTarget = 32'h100;
    step();
    Jump = 0;
    step();
    step();
    check("stall_hold", PCOut, 32'h44);
    Stall = 0;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (PCOut == 32'h100) hits++;
    end
    check("jump_once", 32'(hits), 32'd1);
    check("jump_fetch_pc4", IF_ID_PCPlus4, 32'h108);

    // Exception with Stall and JumpReg while a redirect is held.
    Stall = 1; Jump = 1; JumpTarget = 32'h200;
    step();
    Jump = 0; Exception = 1; JumpReg = 1; JumpRegTarget = 32'h300;
    step();
    check("exc_pc",    PCOut, EXC_PC);
    check("exc_valid", {31'h0, IF_ID_Valid}, 32'h0);
    clear_inputs();
    step();
    check("exc_pend_cleared", PCOut, EXC_PC + 32'd4);
    check("exc_fetch", IF_ID_Instruction, mem(EXC_PC));

    // Flush together with Stall.
    Stall = 1; Flush = 1;
    step();
    check("flush_pc",   PCOut, EXC_PC + 32'd4);
    check("flush_inst", IF_ID_Instruction, NOP);
    clear_inputs();

    // Misaligned register target, then PC wrap at the top of the address space.
    JumpReg = 1; JumpRegTarget = 32'h0000_0123;
    step();
    check("align_pc", PCOut, 32'h120);
    JumpReg = 0; Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    step();
    Jump = 0;
    step();
    check("wrap_pc",  PCOut,         32'h0);
    check("wrap_pc4", IF_ID_PCPlus4, 32'h0);

    // Asynchronous reset while a redirect is held.
    Stall = 1; Jump = 1; JumpTarget = 32'h500;
    step();
    Jump = 0;
    #3 reset = 1'b0;
    #1;
    m_reset();
    check("arst_pc",    PCOut,             32'h0);
    check("arst_inst",  IF_ID_Instruction, NOP);
    check("arst_pc4",   IF_ID_PCPlus4,     32'h0);
    check("arst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    Stall = 0;
    #2 reset = 1'b1;
    step();
    check("arst_discard", PCOut, 32'h4);

    // Random hazard traffic.
    for (int i = 0; i < 400; i++) begin
      Stall         = ($urandom % 4) == 0;
      Flush         = ($urandom % 8) == 0;
      Exception     = ($urandom % 32) == 0;
      JumpReg       = ($urandom % 16) == 0;
      BranchTaken   = ($urandom % 8) == 0;
      Jump          = ($urandom % 8) == 0;
      JumpRegTarget = $urandom;
      BranchTarget  = $urandom;
      JumpTarget    = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
